// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, default datapath width and
// the default reset PC used by the fetch-side logic.
package y86_pkg;

    // Datapath / address width.
    localparam int N = 64;

    // Reset fetch address.
    localparam logic [N-1:0] RESET_PC_DFLT = '0;

    // Y86-64 instruction codes used by PC selection.
    localparam logic [3:0] HALT = 4'h0;
    localparam logic [3:0] NOP  = 4'h1;
    localparam logic [3:0] JXX  = 4'h7;
    localparam logic [3:0] CALL = 4'h8;
    localparam logic [3:0] RET  = 4'h9;

    // Saturating increment: all-ones stays at all-ones.
    function automatic logic [N-1:0] sat_inc(input logic [N-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/pc_trace_counters.sv
// Saturating event counters for fetch tracing: fetch updates, mispredict
// recoveries and return redirects. Only built when PC_TRACE_EN is defined.
module pc_trace_counters
    import y86_pkg::*;
#(
    parameter int n = N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fetch_inc,
    input  logic         mis_inc,
    input  logic         ret_inc,
    output logic [n-1:0] fetch_count,
    output logic [n-1:0] mis_count,
    output logic [n-1:0] ret_count
);

    // Saturating increment at width n.
    function automatic logic [n-1:0] inc_sat(input logic [n-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    // Count events; each counter sticks at all-ones once full.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            mis_count   <= '0;
            ret_count   <= '0;
        end else begin
            if (fetch_inc) fetch_count <= inc_sat(fetch_count);
            if (mis_inc)   mis_count   <= inc_sat(mis_count);
            if (ret_inc)   ret_count   <= inc_sat(ret_count);
        end
    end

endmodule

// File: rtl/pc_select_unit.sv
// Fetch PC selection for the pipelined Y86-64 core. Picks the fetch PC from
// the mispredict recovery in M, the return address in W, or the F-stage
// predicted PC, and freezes fetch after a faulting fetch until a redirect.
// Optional trace counters are enabled with the PC_TRACE_EN macro.
module pc_select_unit
    import y86_pkg::*;
#(
    parameter int           n        = N,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   f_icode,
    input  logic [n-1:0] f_valC,
    input  logic [n-1:0] f_valP,
    input  logic         instr_valid,
    input  logic         imem_error,
    input  logic [3:0]   M_icode,
    input  logic         M_Cnd,
    input  logic [n-1:0] M_valA,
    input  logic [3:0]   W_icode,
    input  logic [n-1:0] W_valM,
    input  logic         F_stall,
    output logic [n-1:0] f_PC,
    output logic [n-1:0] F_predPC,
    output logic         fetch_halted,
    output logic         redirect_mis,
    output logic         redirect_ret
`ifdef PC_TRACE_EN
    ,
    output logic [n-1:0] fetch_count,
    output logic [n-1:0] mis_count,
    output logic [n-1:0] ret_count
`endif
);

    logic [n-1:0] next_pred;
    logic         fault_fetch;
    logic         redirect;

    // Select the fetch PC; a not-taken jump in M outranks a ret in W.
    always_comb begin
        redirect_mis = (M_icode == JXX) && !M_Cnd;
        redirect_ret = !redirect_mis && (W_icode == RET);
        if (redirect_mis)      f_PC = M_valA;
        else if (redirect_ret) f_PC = W_valM;
        else                   f_PC = F_predPC;
    end

    // Predict the next PC: jumps are predicted taken, calls go to the target.
    always_comb begin
        next_pred   = ((f_icode == JXX) || (f_icode == CALL)) ? f_valC : f_valP;
        fault_fetch = (f_icode == HALT) || !instr_valid || imem_error;
        redirect    = redirect_mis || redirect_ret;
    end

    // Predicted-PC register and sticky fetch freeze; a redirect means the
    // frozen fetch was speculative, so it restarts fetch regardless of stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            F_predPC     <= RESET_PC;
            fetch_halted <= 1'b0;
        end else if (redirect) begin
            F_predPC     <= next_pred;
            fetch_halted <= fault_fetch;
        end else if (fetch_halted || F_stall) begin
            F_predPC     <= F_predPC;
            fetch_halted <= fetch_halted;
        end else if (fault_fetch) begin
            F_predPC     <= f_PC;
            fetch_halted <= 1'b1;
        end else begin
            F_predPC     <= next_pred;
        end
    end

`ifdef PC_TRACE_EN
    logic fetch_inc;

    // A fetch counts when the predicted PC actually advances or is redirected.
    always_comb begin
        fetch_inc = redirect || (!fetch_halted && !F_stall);
    end

    pc_trace_counters #(
        .n(n)
    ) u_trace (
        .clk        (clk),
        .rst        (rst),
        .fetch_inc  (fetch_inc),
        .mis_inc    (redirect_mis),
        .ret_inc    (redirect_ret),
        .fetch_count(fetch_count),
        .mis_count  (mis_count),
        .ret_count  (ret_count)
    );
`endif

endmodule

// File: tb/tb_pc_select_unit.sv
// Directed testbench for pc_select_unit: selection priority, prediction,
// stall, fault freeze and resume, and reset during a freeze.
module tb_pc_select_unit;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   f_icode;
    logic [W-1:0] f_valC;
    logic [W-1:0] f_valP;
    logic         instr_valid;
    logic         imem_error;
    logic [3:0]   M_icode;
    logic         M_Cnd;
    logic [W-1:0] M_valA;
    logic [3:0]   W_icode;
    logic [W-1:0] W_valM;
    logic         F_stall;
    logic [W-1:0] f_PC;
    logic [W-1:0] F_predPC;
    logic         fetch_halted;
    logic         redirect_mis;
    logic         redirect_ret;
`ifdef PC_TRACE_EN
    logic [W-1:0] fetch_count;
    logic [W-1:0] mis_count;
    logic [W-1:0] ret_count;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pc_select_unit #(
        .n(W),
        .RESET_PC('0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .f_icode     (f_icode),
        .f_valC      (f_valC),
        .f_valP      (f_valP),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .M_icode     (M_icode),
        .M_Cnd       (M_Cnd),
        .M_valA      (M_valA),
        .W_icode     (W_icode),
        .W_valM      (W_valM),
        .F_stall     (F_stall),
        .f_PC        (f_PC),
        .F_predPC    (F_predPC),
        .fetch_halted(fetch_halted),
        .redirect_mis(redirect_mis),
        .redirect_ret(redirect_ret)
`ifdef PC_TRACE_EN
        ,
        .fetch_count (fetch_count),
        .mis_count   (mis_count),
        .ret_count   (ret_count)
`endif
    );

    task automatic idle_mw();
        M_icode = 4'h1; M_Cnd = 1'b1; M_valA = '0;
        W_icode = 4'h1; W_valM = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; F_stall = 1'b0;
        f_icode = 4'h1; f_valC = '0; f_valP = '0; instr_valid = 1'b1; imem_error = 1'b0;
        idle_mw();
        step(); step();
        total++; if (F_predPC !== 64'h0) $display("FAIL reset_predpc: got %h want %h", F_predPC, 64'h0); else passed++;
        total++; if (fetch_halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", fetch_halted); else passed++;
        total++; if ({redirect_mis, redirect_ret} !== 2'b00) $display("FAIL reset_redirects: got %b want 00", {redirect_mis, redirect_ret}); else passed++;
`ifdef PC_TRACE_EN
        total++; if ({fetch_count, mis_count, ret_count} !== '0) $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", fetch_count, mis_count, ret_count); else passed++;
`endif
        rst = 1'b0;
    endtask

    task automatic test_predict();
        f_icode = 4'h1; f_valP = 64'h2;
        #1;
        total++; if (f_PC !== 64'h0) $display("FAIL first_fpc: got %h want %h", f_PC, 64'h0); else passed++;
        step();
        total++; if (F_predPC !== 64'h2) $display("FAIL nop_pred: got %h want %h", F_predPC, 64'h2); else passed++;
        f_icode = 4'h7; f_valC = 64'h40; f_valP = 64'h9;
        step();
        total++; if (F_predPC !== 64'h40) $display("FAIL jxx_taken_pred: got %h want %h", F_predPC, 64'h40); else passed++;
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h9;
        f_icode = 4'h1; f_valP = 64'hB;
        #1;
        total++; if (f_PC !== 64'h9) $display("FAIL mis_fpc: got %h want %h", f_PC, 64'h9); else passed++;
        total++; if (redirect_mis !== 1'b1) $display("FAIL mis_flag: got %b want 1", redirect_mis); else passed++;
        step();
        total++; if (F_predPC !== 64'hB) $display("FAIL mis_next_pred: got %h want %h", F_predPC, 64'hB); else passed++;
        idle_mw();
        M_Cnd = 1'b1; M_icode = 4'h7;
        #1;
        total++; if (redirect_mis !== 1'b0) $display("FAIL taken_jxx_no_redirect: got %b want 0", redirect_mis); else passed++;
        idle_mw();
    endtask

    task automatic test_priority();
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h20;
        W_icode = 4'h9; W_valM = 64'h80;
        f_icode = 4'h8; f_valC = 64'h10; f_valP = 64'h29;
        #1;
        total++; if (f_PC !== 64'h20) $display("FAIL prio_fpc: got %h want %h", f_PC, 64'h20); else passed++;
        total++; if ({redirect_mis, redirect_ret} !== 2'b10) $display("FAIL prio_flags: got %b want 10", {redirect_mis, redirect_ret}); else passed++;
        step();
        total++; if (F_predPC !== 64'h10) $display("FAIL call_pred: got %h want %h", F_predPC, 64'h10); else passed++;
        idle_mw();
    endtask

    task automatic test_stall();
        F_stall = 1'b1; f_icode = 4'h1; f_valP = 64'h99;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (F_predPC !== 64'h10) $display("FAIL stall_hold%0d: got %h want %h", i, F_predPC, 64'h10); else passed++;
        end
        W_icode = 4'h9; W_valM = 64'h30; f_valP = 64'h32;
        #1;
        total++; if (f_PC !== 64'h30) $display("FAIL ret_fpc: got %h want %h", f_PC, 64'h30); else passed++;
        total++; if ({redirect_mis, redirect_ret} !== 2'b01) $display("FAIL ret_flags: got %b want 01", {redirect_mis, redirect_ret}); else passed++;
        step();
        total++; if (F_predPC !== 64'h32) $display("FAIL ret_over_stall: got %h want %h", F_predPC, 64'h32); else passed++;
        idle_mw(); F_stall = 1'b0;
    endtask

    task automatic test_halt();
        f_icode = 4'h1; f_valP = 64'h18;
        step();
        f_icode = 4'h0; f_valP = 64'h19;
        #1;
        total++; if (f_PC !== 64'h18) $display("FAIL halt_fpc: got %h want %h", f_PC, 64'h18); else passed++;
        step();
        total++; if (fetch_halted !== 1'b1) $display("FAIL halt_set: got %b want 1", fetch_halted); else passed++;
        total++; if (F_predPC !== 64'h18) $display("FAIL halt_park: got %h want %h", F_predPC, 64'h18); else passed++;
        f_icode = 4'h1; f_valP = 64'h77;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if ({fetch_halted, F_predPC} !== {1'b1, 64'h18}) $display("FAIL halt_hold%0d: got %b/%h want 1/%h", i, fetch_halted, F_predPC, 64'h18); else passed++;
        end
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h50; f_valP = 64'h52;
        #1;
        total++; if (f_PC !== 64'h50) $display("FAIL resume_fpc: got %h want %h", f_PC, 64'h50); else passed++;
        step();
        total++; if (fetch_halted !== 1'b0) $display("FAIL resume_clear: got %b want 0", fetch_halted); else passed++;
        total++; if (F_predPC !== 64'h52) $display("FAIL resume_pred: got %h want %h", F_predPC, 64'h52); else passed++;
        idle_mw();
        instr_valid = 1'b0; f_valP = 64'h60;
        step();
        total++; if ({fetch_halted, F_predPC} !== {1'b1, 64'h52}) $display("FAIL invalid_park: got %b/%h want 1/%h", fetch_halted, F_predPC, 64'h52); else passed++;
        instr_valid = 1'b1;
    endtask

    task automatic test_reset_mid();
`ifdef PC_TRACE_EN
        total++; if (fetch_count !== 64'd9) $display("FAIL fetch_count: got %0d want 9", fetch_count); else passed++;
        total++; if (mis_count !== 64'd3) $display("FAIL mis_count: got %0d want 3", mis_count); else passed++;
        total++; if (ret_count !== 64'd1) $display("FAIL ret_count: got %0d want 1", ret_count); else passed++;
`endif
        W_icode = 4'h9; W_valM = 64'h90; f_valP = 64'h94; rst = 1'b1;
        step();
        total++; if (F_predPC !== 64'h0) $display("FAIL rst_mid_pred: got %h want %h", F_predPC, 64'h0); else passed++;
        total++; if (fetch_halted !== 1'b0) $display("FAIL rst_mid_halt: got %b want 0", fetch_halted); else passed++;
`ifdef PC_TRACE_EN
        total++; if ({fetch_count, mis_count, ret_count} !== '0) $display("FAIL rst_mid_counters: got %0d/%0d/%0d want 0/0/0", fetch_count, mis_count, ret_count); else passed++;
`endif
        rst = 1'b0; idle_mw();
        #1;
        total++; if (f_PC !== 64'h0) $display("FAIL post_rst_fpc: got %h want %h", f_PC, 64'h0); else passed++;
    endtask

    initial begin
        test_reset();
        test_predict();
        test_priority();
        test_stall();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
